// File: rtl/axi_dma_burst_splitter.sv
// axi_dma_burst_splitter: splits one DMA command into AXI address bursts bounded by MAX_BURST_LEN and 4 KB pages; define AXI_DMA_SPLITTER_STATS_EN for burst statistics
module axi_dma_burst_splitter #(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 64,
    parameter int MAX_BURST_LEN = 256,
    parameter int USE_DST       = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_WD-1:0] cmd_src_addr,
    input  logic [ADDR_WD-1:0] cmd_dst_addr,
    input  logic [1:0]         cmd_burst,
    input  logic [ADDR_WD-1:0] cmd_len,
    input  logic [2:0]         cmd_size,
    output logic               ax_valid,
    input  logic               ax_ready,
    output logic [ADDR_WD-1:0] ax_addr,
    output logic [7:0]         ax_len,
    output logic [2:0]         ax_size,
    output logic [1:0]         ax_burst,
    output logic               done,
    output logic               err
`ifdef AXI_DMA_SPLITTER_STATS_EN
    ,
    output logic [15:0]        burst_cnt,
    output logic [15:0]        last_cmd_bursts
`endif
);
    typedef enum logic [1:0] {IDLE, CHECK, CALC, ISSUE} state_t;
    localparam int MAX_SIZE  = $clog2(DATA_WD / 8);
    localparam int CAP_FIXED = MAX_BURST_LEN < 16 ? MAX_BURST_LEN : 16;
    state_t state, state_nxt;
    logic [ADDR_WD-1:0] addr, rem, aligned;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [12:0] beats, beats_c, bnd, cap, lim;
    logic        bad, last, hs;
    assign cmd_ready = state == IDLE && !rst;
    assign ax_valid  = state == ISSUE;
    assign hs        = ax_valid && ax_ready;
    assign ax_size   = size_q;
    assign ax_burst  = burst_q;
    assign aligned   = addr & ~((ADDR_WD'(1) << size_q) - ADDR_WD'(1));
    assign bnd       = (13'd4096 - {1'b0, aligned[11:0]}) >> size_q;
    assign cap       = burst_q == 2'd1 ? 13'(MAX_BURST_LEN) : 13'(CAP_FIXED);
    assign lim       = (burst_q == 2'd1 && bnd < cap) ? bnd : cap;
    assign beats_c   = rem < ADDR_WD'(lim) ? rem[12:0] : lim;
    assign bad       = burst_q[1] || size_q > 3'(MAX_SIZE);
    assign last      = rem == ADDR_WD'(beats);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // next-state: accept, validate, size a burst, hold it until accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cmd_valid ? CHECK : IDLE;
            CHECK:   state_nxt = (bad || rem == '0) ? IDLE : CALC;
            CALC:    state_nxt = ISSUE;
            ISSUE:   state_nxt = hs ? (last ? IDLE : CALC) : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end
    // command latch, burst sizing, progress tracking and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            rem     <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beats   <= '0;
            ax_addr <= '0;
            ax_len  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    addr    <= USE_DST != 0 ? cmd_dst_addr : cmd_src_addr;
                    rem     <= cmd_len;
                    size_q  <= cmd_size;
                    burst_q <= cmd_burst;
                end
                CHECK: begin
                    done <= bad || rem == '0;
                    err  <= bad;
                end
                CALC: begin
                    ax_addr <= addr;
                    ax_len  <= 8'(beats_c - 13'd1);
                    beats   <= beats_c;
                end
                ISSUE: if (hs) begin
                    rem  <= rem - ADDR_WD'(beats);
                    addr <= burst_q == 2'd1 ? aligned + (ADDR_WD'(beats) << size_q) : addr;
                    done <= last;
                end
                default: ;
            endcase
        end
    end
`ifdef AXI_DMA_SPLITTER_STATS_EN
    logic [15:0] cmd_bursts;
    // saturating handshake counters; per-command count published with done
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt       <= '0;
            cmd_bursts      <= '0;
            last_cmd_bursts <= '0;
        end else begin
            if (hs && burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
            if (cmd_valid && cmd_ready) cmd_bursts <= '0;
            else if (hs && cmd_bursts != 16'hFFFF) cmd_bursts <= cmd_bursts + 16'd1;
            if (state == CHECK && (bad || rem == '0)) last_cmd_bursts <= '0;
            else if (hs && last) last_cmd_bursts <= cmd_bursts + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
// tb_axi_dma_burst_splitter: randomized and directed checks of the burst splitter against a page/length reference model
module tb_axi_dma_burst_splitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src_addr = '0;
    logic [31:0] cmd_dst_addr = '0;
    logic [1:0]  cmd_burst = '0;
    logic [31:0] cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic        ax_valid;
    logic        ax_ready = 1'b0;
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic        done;
    logic        err;
    int checks = 0;
    int failures = 0;
`ifdef AXI_DMA_SPLITTER_STATS_EN
    logic [15:0] burst_cnt, last_cmd_bursts;
`endif

    axi_dma_burst_splitter dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_burst(cmd_burst),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .ax_valid(ax_valid), .ax_ready(ax_ready),
        .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
        .done(done), .err(err)
`ifdef AXI_DMA_SPLITTER_STATS_EN
        , .burst_cnt(burst_cnt), .last_cmd_bursts(last_cmd_bursts)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b v=%b a=%h l=%h s=%h b=%h d=%b e=%b want all 0",
                     cmd_ready, ax_valid, ax_addr, ax_len, ax_size, ax_burst, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", cmd_ready);
        end
    endtask

    // Drives one command, computes the expected burst list from the page/length rules,
    // and checks latency, contents, stability under stalls and the completion pulse.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int stall);
        logic [31:0] ea[$];
        int          el[$];
        logic [31:0] ad, al;
        longint      rem;
        int          lim, bnd, beats, cyc, hold, exp_cyc;
        bit          rej, newb;
        rej = (b >= 2) || (s > 3);
        rem = l;
        ad  = a;
        while (rem > 0 && !rej) begin
            al  = ad & ~((32'h1 << s) - 32'h1);
            lim = (b == 1) ? 256 : 16;
            if (b == 1) begin
                bnd = (4096 - int'(al[11:0])) / (1 << s);
                if (bnd < lim) lim = bnd;
            end
            beats = (rem < lim) ? int'(rem) : lim;
            ea.push_back(ad);
            el.push_back(beats - 1);
            rem -= beats;
            if (b == 1) ad = al + 32'(beats * (1 << s));
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle got %b want 1", cmd_ready);
        end
        cmd_valid    = 1'b1;
        cmd_src_addr = a;
        cmd_dst_addr = ~a;
        cmd_len      = l;
        cmd_size     = s;
        cmd_burst    = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_src_addr = $urandom;
        cmd_len = $urandom;
        if (rej || l == 0) begin
            @(negedge clk);
            checks++;
            if ({ax_valid, done, err} !== {1'b0, 1'b1, rej}) begin
                failures++;
                $display("FAIL short_cmd a=%h l=%0d s=%0d b=%0d got v=%b d=%b e=%b want v=0 d=1 e=%b",
                         a, l, s, b, ax_valid, done, err, rej);
            end
`ifdef AXI_DMA_SPLITTER_STATS_EN
            checks++;
            if (last_cmd_bursts !== 16'd0) begin
                failures++;
                $display("FAIL stats_short got %0d want 0", last_cmd_bursts);
            end
`endif
            return;
        end
        cyc = 1; hold = 0; newb = 1; exp_cyc = 3;
        begin
            int nb;
            nb = ea.size();
            while (ea.size() > 0 && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL early_done cyc=%0d got %b want 0", cyc, done);
                end
                if (ax_valid) begin
                    if (newb) begin
                        checks++;
                        if (cyc != exp_cyc) begin
                            failures++;
                            $display("FAIL burst_latency got cyc %0d want %0d", cyc, exp_cyc);
                        end
                        newb = 0;
                    end
                    checks++;
                    if ({ax_addr, ax_len, ax_size, ax_burst} !== {ea[0], 8'(el[0]), s, b}) begin
                        failures++;
                        $display("FAIL burst a=%h l=%0d s=%0d b=%0d got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d",
                                 a, l, s, b, ax_addr, ax_len, ax_size, ax_burst, ea[0], el[0]);
                    end
                    if (hold < stall) begin
                        ax_ready = 1'b0;
                        hold++;
                    end else begin
                        ax_ready = 1'b1;
                        void'(ea.pop_front());
                        void'(el.pop_front());
                        hold = 0;
                        newb = 1;
                        exp_cyc = cyc + 2;
                    end
                end else begin
                    ax_ready = ($urandom_range(0, 1) == 1);
                end
            end
            @(negedge clk);
            ax_ready = 1'b0;
            checks++;
            if (ea.size() != 0) begin
                failures++;
                $display("FAIL burst_timeout remaining %0d want 0", ea.size());
            end
            checks++;
            if ({done, err, cmd_ready, ax_valid} !== 4'b1010) begin
                failures++;
                $display("FAIL completion got d=%b e=%b rdy=%b v=%b want d=1 e=0 rdy=1 v=0",
                         done, err, cmd_ready, ax_valid);
            end
`ifdef AXI_DMA_SPLITTER_STATS_EN
            checks++;
            if (last_cmd_bursts !== 16'(nb)) begin
                failures++;
                $display("FAIL stats_bursts got %0d want %0d", last_cmd_bursts, nb);
            end
`endif
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_width got %b want 0", done);
            end
        end
    endtask

    task automatic test_directed();
        run_cmd(32'h1000, 16, 3, 1, 0);
        run_cmd(32'h0FF0, 8, 3, 1, 0);
        run_cmd(32'h0000, 600, 2, 1, 0);
        run_cmd(32'h0FF5, 5, 2, 1, 0);
        run_cmd(32'hFFFF_FFF8, 4, 3, 1, 0);
    endtask

    task automatic test_stall();
        run_cmd(32'h0000, 600, 2, 1, 5);
        run_cmd(32'h0040, 40, 2, 0, 3);
    endtask

    task automatic test_reject();
        run_cmd(32'h0040, 40, 2, 0, 0);
        run_cmd(32'h0100, 8, 2, 2, 0);
        run_cmd(32'h0100, 8, 2, 3, 0);
        run_cmd(32'h0100, 0, 2, 1, 0);
        run_cmd(32'h0100, 8, 4, 1, 0);
    endtask

    task automatic test_rst_mid();
        int cyc;
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src_addr = 32'h100; cmd_len = 32; cmd_size = 3; cmd_burst = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!ax_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ax_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue got v=%b want 1", ax_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ax_valid, cmd_ready, done, ax_addr, ax_len} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got v=%b rdy=%b d=%b a=%h l=%h want all 0",
                     ax_valid, cmd_ready, done, ax_addr, ax_len);
        end
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_mid_no_done got done pulse want none");
        end
        run_cmd(32'h2000, 20, 3, 1, 1);
    endtask

    task automatic test_random();
        logic [31:0] a, l;
        logic [2:0]  s;
        logic [1:0]  b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - $urandom_range(1, 64));
            l = 32'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 600));
            s = 3'($urandom_range(0, 9) == 0 ? 4 : $urandom_range(0, 3));
            b = 2'($urandom_range(0, 7) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1));
            run_cmd(a, l, s, b, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reject();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_dma_burst_splitter.md
Name: axi_dma_burst_splitter

Overview:
Consumes one DMA command (valid/ready, src_addr, dst_addr, burst, len, size) and splits it into a sequence of legal AXI address-channel bursts. Bursts are limited by MAX_BURST_LEN and never cross a 4 KB boundary.
Sits directly downstream of the DMA command interface. It is instantiated twice: once with USE_DST=0 for the read (AR) channel and once with USE_DST=1 for the write (AW) channel.

Parameters:
ADDR_WD, 32, address and len width
DATA_WD, 64, AXI data bus width in bits; sets the maximum legal size
MAX_BURST_LEN, 256, maximum beats per INCR burst (1..256)
USE_DST, 0, 0 = split src_addr, 1 = split dst_addr

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when valid&&ready
cmd_src_addr  input  ADDR_WD  source byte address
cmd_dst_addr  input  ADDR_WD  destination byte address
cmd_burst  input  2  AXI burst type (0 FIXED, 1 INCR, 2 WRAP)
cmd_len  input  ADDR_WD  total transfer length in beats
cmd_size  input  3  log2(bytes per beat)
ax_valid  output  1  address burst valid
ax_ready  input  1  address burst accepted
ax_addr  output  ADDR_WD  burst start address
ax_len  output  8  AXI len (beats-1)
ax_size  output  3  copy of latched cmd_size
ax_burst  output  2  copy of latched cmd_burst
done  output  1  one-cycle pulse after the last burst handshake or after a reject
err  output  1  one-cycle pulse, concurrent with done, when a command is rejected

Behaviour:
- Reset values: cmd_ready=0, ax_valid=0, ax_addr=0, ax_len=0, ax_size=0, ax_burst=0, done=0, err=0, state=IDLE.
- cmd_ready=1 only in IDLE and not in rst.
- State IDLE:
  - On cmd_valid && cmd_ready, latch the selected address, len, size and burst.
  - Go to CHECK.
- State CHECK (1 cycle):
  - Reject if cmd_burst==WRAP, cmd_burst==3, or cmd_size > log2(DATA_WD/8). On reject: done=1 and err=1 for one cycle, then IDLE.
  - If len==0: done=1, err=0, then IDLE. No burst is issued.
  - Otherwise go to CALC.
- State CALC (1 cycle):
  - a = addr with bits [size-1:0] cleared.
  - INCR: bnd = (4096 - a[11:0]) >> size. FIXED: bnd = infinity.
  - cap = MAX_BURST_LEN for INCR; cap = min(16, MAX_BURST_LEN) for FIXED.
  - beats = min(remaining, cap, bnd).
  - Register ax_addr=addr (first burst keeps the unaligned address; later bursts use aligned addresses) and ax_len=beats-1.
  - Go to ISSUE.
- State ISSUE:
  - ax_valid=1. ax_addr/ax_len/ax_size/ax_burst are held stable until ax_ready.
  - On the handshake: remaining -= beats. For INCR, addr = a + (beats << size); for FIXED, addr is unchanged.
  - If remaining==0: go to IDLE and assert done for one cycle in the IDLE cycle (cmd_ready is also 1 in that cycle).
  - Otherwise go to CALC.
- Latency: command accept at cycle N, first ax_valid at N+3. Each subsequent burst is issued 2 cycles after the previous handshake. One burst is in flight at a time.
- Address arithmetic is ADDR_WD wide and wraps modulo 2^ADDR_WD without error. remaining is ADDR_WD wide.
- The 4 KB computation uses a 13-bit intermediate, so a[11:0]==0 gives bnd=4096>>size.
- rst mid-operation: the command is abandoned, all outputs return to reset values the next cycle, and no done is issued.
- cmd inputs are ignored outside IDLE.

Optional Feature:
AXI_DMA_SPLITTER_STATS_EN
- Defined:
  - Adds output burst_cnt (16 bits). It increments on every ax handshake, saturates at 0xFFFF, and is cleared by rst.
  - Adds output last_cmd_bursts (16 bits). It is loaded with the burst count of the most recent command when done is pulsed, and reads 0 after a reject or zero-length command.
- Not defined: neither port nor its counter logic exists.

Test Plan:
- INCR, addr 0x1000, len 16, size 3, ax_ready=1 -> one burst: addr 0x1000, len 15, size 3, burst 1; done 1 cycle after the handshake; err=0.
- INCR, addr 0x0FF0, len 8, size 3 -> two bursts: (0x0FF0, len 1) then (0x1000, len 5); no 4 KB crossing.
- INCR, addr 0, len 600, size 2, MAX_BURST_LEN=256 -> bursts of 256, 256 and 88 beats at addresses 0x000, 0x400 and 0x800. Repeat with ax_ready held low 5 cycles per burst -> outputs stay stable while held and the same sequence results.
- FIXED, addr 0x40, len 40, size 2 -> three bursts at 0x40 with ax_len 15, 15, 7; WRAP command -> no ax_valid, done=err=1 after 2 cycles.
- len 0 -> no ax_valid, done=1, err=0; size 4 with DATA_WD=64 -> err=1.
- rst asserted in ISSUE with ax_ready=0 -> next cycle ax_valid=0 and cmd_ready=0 while rst is high; a new command after rst is processed normally, with no done from the abandoned command.
